// File: rtl/sys_mem_pkg.sv
// Shared constants and helpers for the unified memory responder.
// MMIO byte offsets, STATUS bit positions, console FIFO depth and the fetch NOP.
package sys_mem_pkg;

    localparam logic [3:0] OFF_CONSOLE_TX = 4'h0;
    localparam logic [3:0] OFF_STATUS     = 4'h4;
    localparam logic [3:0] OFF_CYCLE_LO   = 4'h8;
    localparam logic [3:0] OFF_CYCLE_HI   = 4'hC;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_DROP    = 2;
    localparam int unsigned ST_BUS_ERR = 3;

    localparam int unsigned CON_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        RegionRam,
        RegionMmio,
        RegionNone
    } region_e;

    // Byte-lane merge of a masked store into an existing word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Circular-buffer FIFO feeding the console drain port.
// Head reads as zero when empty; a push into a full FIFO succeeds only if a pop frees a slot.
module console_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] buffer [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count and pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            buffer[wr_ptr_q] <= push_data;
        end
    end

    assign head = empty ? '0 : buffer[rd_ptr_q];

endmodule

// File: rtl/sys_mem.sv
// Unified instruction/data memory with byte-masked RAM and a small MMIO window
// (console TX FIFO, 64-bit cycle counter, sticky STATUS flags).
module sys_mem
    import sys_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 4096,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wmask,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [7:0]            con_data,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic                  bus_err
);

    localparam int unsigned           IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);
    localparam logic [ADDR_WIDTH-1:0] MMIO_SIZE = ADDR_WIDTH'(16);

    logic [DATA_WIDTH-1:0] ram [MEM_WORDS];

    region_e               region;
    logic [ADDR_WIDTH-1:0] addr_off;
    logic [3:0]            mmio_off;
    logic [IDX_W-1:0]      ram_idx;
    logic [IDX_W-1:0]      pc_idx;

    logic        ram_we;
    logic        fifo_push;
    logic        status_wr;
    logic        bad_wr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        drop_set;
    logic [3:0]  status;

    logic        drop_q, drop_d;
    logic        bus_err_q, bus_err_d;
    logic [63:0] cycle_q;
    logic [63:0] cycle_d;

    // Address decode. Subtracting the base first lets one unsigned compare cover the window.
    assign addr_off = addr - MMIO_BASE;
    assign mmio_off = {addr_off[3:2], 2'b00};
    assign ram_idx  = addr[IDX_W+1:2];
    assign pc_idx   = pc[IDX_W+1:2];

    always_comb begin
        if (addr < RAM_BYTES) begin
            region = RegionRam;
        end else if (addr_off < MMIO_SIZE) begin
            region = RegionMmio;
        end else begin
            region = RegionNone;
        end
    end

    assign ram_we    = we && (region == RegionRam);
    assign fifo_push = we && (region == RegionMmio) && (mmio_off == OFF_CONSOLE_TX) && wmask[0];
    assign status_wr = we && (region == RegionMmio) && (mmio_off == OFF_STATUS) && wmask[0];
    assign bad_wr    = we && (region == RegionNone);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= merge_lanes(ram[ram_idx], wdata, wmask);
        end
    end

    assign instr = (pc < RAM_BYTES) ? ram[pc_idx] : NOP_INSTR;

    console_fifo #(
        .DEPTH (CON_FIFO_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wdata[7:0]),
        .pop       (con_ready),
        .head      (con_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign con_valid = !fifo_empty;

    // A full FIFO only loses the byte when the consumer is not draining this cycle.
    assign drop_set = fifo_push && fifo_full && !con_ready;

    always_comb begin
        drop_d    = drop_q;
        bus_err_d = bus_err_q;
        if (status_wr && wdata[ST_DROP]) begin
            drop_d = 1'b0;
        end
        if (status_wr && wdata[ST_BUS_ERR]) begin
            bus_err_d = 1'b0;
        end
        if (drop_set) begin
            drop_d = 1'b1;
        end
        if (bad_wr) begin
            bus_err_d = 1'b1;
        end
    end

    assign cycle_d = cycle_q + 64'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q    <= 1'b0;
            bus_err_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            drop_q    <= drop_d;
            bus_err_q <= bus_err_d;
            cycle_q   <= cycle_d;
        end
    end

    assign bus_err = bus_err_q;

    always_comb begin
        status             = '0;
        status[ST_EMPTY]   = fifo_empty;
        status[ST_FULL]    = fifo_full;
        status[ST_DROP]    = drop_q;
        status[ST_BUS_ERR] = bus_err_q;
    end

    always_comb begin
        rdata = '0;
        unique case (region)
            RegionRam: rdata = ram[ram_idx];
            RegionMmio: begin
                case (mmio_off)
                    OFF_STATUS:   rdata = {{(DATA_WIDTH-4){1'b0}}, status};
                    OFF_CYCLE_LO: rdata = cycle_q[31:0];
                    OFF_CYCLE_HI: rdata = cycle_q[63:32];
                    default:      rdata = '0;
                endcase
            end
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sys_mem.sv
// Self-checking bench for sys_mem: behavioural model (word array, byte queue, flags, counter)
// compared every cycle, plus directed literal checks and a randomized phase.
module tb_sys_mem;

    localparam int          MW        = 64;
    localparam int          RAM_BYTES = MW * 4;
    localparam logic [31:0] BASE      = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    sys_mem #(
        .MEM_WORDS (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr     (instr),
        .addr      (addr),
        .wdata     (wdata),
        .wmask     (wmask),
        .we        (we),
        .rdata     (rdata),
        .con_data  (con_data),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [MW];
    logic [7:0]  m_q [$];
    bit          m_drop = 0;
    bit          m_berr = 0;
    logic [63:0] m_cnt  = 0;
    bit          force_cnt = 0;
    bit          m_pop;
    bit          m_push;

    always @(posedge clk) begin
        if (we && addr < RAM_BYTES) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) m_ram[addr / 4][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_drop = 0;
            m_berr = 0;
            m_cnt  = 0;
        end else begin
            m_pop  = (m_q.size() != 0) && con_ready;
            m_push = 0;
            if (we && addr >= RAM_BYTES) begin
                if (addr >= BASE && addr - BASE < 16) begin
                    case ((addr - BASE) / 4)
                        0: if (wmask[0]) m_push = 1;
                        1: if (wmask[0]) begin
                            if (wdata[2]) m_drop = 0;
                            if (wdata[3]) m_berr = 0;
                        end
                        default: ;
                    endcase
                end else begin
                    m_berr = 1;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < 4) m_q.push_back(wdata[7:0]);
                else m_drop = 1;
            end
            m_cnt = force_cnt ? 64'h0000_0000_FFFF_FFFF : m_cnt + 64'd1;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (a < RAM_BYTES) return m_ram[a / 4];
        if (a >= BASE && a - BASE < 16) begin
            case ((a - BASE) / 4)
                1: return {28'b0, m_berr, m_drop, m_q.size() == 4, m_q.size() == 0};
                2: return m_cnt[31:0];
                3: return m_cnt[63:32];
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("instr", instr, (pc < RAM_BYTES) ? m_ram[pc / 4] : 32'h13);
            chk("rdata", rdata, exp_rdata(addr));
            chk("con_valid", con_valid, m_q.size() != 0);
            chk("con_data", con_data, (m_q.size() != 0) ? m_q[0] : 8'h0);
            chk("bus_err", bus_err, m_berr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        we    = 1;
        step();
        we    = 0;
    endtask

    task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        @(negedge clk);
        chk(name, rdata, exp);
        step();
    endtask

    task automatic drain_lit(input string name, input logic [7:0] exp);
        @(negedge clk);
        chk(name, con_data, exp);
        step();
    endtask

    initial begin
        logic [7:0] s5 [5];
        logic [7:0] s4 [4];
        int sel;

        rst = 1; pc = 0; addr = 0; wdata = 0; wmask = 0; we = 0; con_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        addr = BASE + 4; #1;
        chk("reset_status", rdata, 32'h1);
        addr = BASE + 8; #1;
        chk("reset_cycle_lo", rdata, 32'h0);
        chk("reset_con_valid", con_valid, 1'b0);
        chk("reset_con_data", con_data, 8'h0);
        chk("reset_bus_err", bus_err, 1'b0);
        rst = 0;
        step();

        for (int i = 0; i < MW; i++) wr(i * 4, $urandom, 4'hF);
        checking = 1;

        // masked store merge
        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h10, 32'h00AA_0000, 4'b0100);
        rd_lit("ram_merge", 32'h10, 32'hDEAA_BEEF);

        // fetch port and out-of-range NOP
        wr(32'h0, 32'h0050_0093, 4'hF);
        pc = 0; #1;
        chk("fetch_word0", instr, 32'h0050_0093);
        pc = RAM_BYTES; #1;
        chk("fetch_nop", instr, 32'h0000_0013);
        rd_lit("fetch_no_err", BASE + 4, 32'h1);

        // fill past full, then drain
        s5 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        con_ready = 0;
        for (int i = 0; i < 5; i++) wr(BASE, {24'h0, s5[i]}, 4'b0001);
        rd_lit("status_full_drop", BASE + 4, 32'h6);
        con_ready = 1;
        for (int i = 0; i < 4; i++) drain_lit("drain_abcd", s5[i]);
        @(negedge clk);
        chk("drained_valid", con_valid, 1'b0);
        chk("status_empty_drop", rdata, 32'h5);
        step();

        // push into full FIFO while draining: accepted, no drop
        con_ready = 0;
        wr(BASE + 4, 32'h4, 4'hF);
        s4 = '{8'h50, 8'h51, 8'h52, 8'h53};
        for (int i = 0; i < 4; i++) wr(BASE, {24'h0, s4[i]}, 4'b0001);
        con_ready = 1;
        wr(BASE, 32'h58, 4'b0001);
        con_ready = 0;
        rd_lit("full_push_pop", BASE + 4, 32'h2);
        con_ready = 1;
        drain_lit("drain_q", 8'h51);
        drain_lit("drain_r", 8'h52);
        drain_lit("drain_s", 8'h53);
        drain_lit("drain_x", 8'h58);
        con_ready = 0;

        // cycle counter after reset and across the 32-bit carry
        rst = 1;
        step();
        rst = 0;
        addr = BASE + 8;
        repeat (10) step();
        @(negedge clk);
        chk("cycle_lo_10", rdata, 32'd10);
        step();
        force dut.cycle_d = 64'h0000_0000_FFFF_FFFF;
        force_cnt = 1;
        step();
        release dut.cycle_d;
        force_cnt = 0;
        addr = BASE + 8;  #1;
        chk("cycle_lo_ones", rdata, 32'hFFFF_FFFF);
        addr = BASE + 12; #1;
        chk("cycle_hi_zero", rdata, 32'h0);
        step();
        addr = BASE + 8;  #1;
        chk("cycle_lo_wrap", rdata, 32'h0);
        addr = BASE + 12; #1;
        chk("cycle_hi_carry", rdata, 32'h1);
        step();

        // unmapped store sets bus_err, W1C clears it
        wr(32'h2000_0000, 32'h1234_5678, 4'hF);
        #1;
        chk("bus_err_set", bus_err, 1'b1);
        rd_lit("ram_untouched", 32'h10, 32'hDEAA_BEEF);
        wr(BASE + 4, 32'h8, 4'hF);
        #1;
        chk("bus_err_w1c", bus_err, 1'b0);
        step();

        // asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) wr(BASE, 32'h60 + i, 4'b0001);
        con_ready = 1;
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("async_rst_valid", con_valid, 1'b0);
        chk("async_rst_data", con_data, 8'h0);
        step();
        rst = 0;
        con_ready = 0;
        rd_lit("ram_kept_rst", 32'h10, 32'hDEAA_BEEF);
        pc = 0; #1;
        chk("fetch_kept_rst", instr, 32'h0050_0093);
        step();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       addr = $urandom_range(0, RAM_BYTES - 1);
            else if (sel < 8)  addr = BASE + $urandom_range(0, 15);
            else if (sel == 8) addr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
            else               addr = RAM_BYTES + $urandom_range(0, 1023);
            we        = ($urandom_range(0, 2) == 0);
            wmask     = 4'($urandom);
            wdata     = $urandom;
            con_ready = 1'($urandom_range(0, 1));
            pc        = ($urandom_range(0, 3) != 0) ? $urandom_range(0, RAM_BYTES - 1) : $urandom;
            step();
        end
        we = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
